test_pattern_gen: RTL and testbench
===================================

// Module: test_pattern_gen
// PURPOSE
//   Parametrised, registered test-pattern source for the VGA pixel pipeline.
//   Sits after the sync/timing generator. Takes the pixel coordinates and
//   returns 8-bit R/G/B. Supports four modes: N static vertical bars,
//   horizontally scrolling bars, checkerboard, and grey ramp.
//   Mode and scroll state change only on frame boundaries, so no frame tears.
// PARAMETERS
//   HVID        640  active pixels per line; HVID % N_BARS must be 0
//   VVID        480  active lines per frame
//   N_BARS      4    number of vertical bars, 1..8; BAR_W = HVID/N_BARS
//   SCROLL_STEP 4    pixels the bars move per frame in scroll mode, < HVID
//   CHK_LOG2    5    checker square size = 2**CHK_LOG2 pixels
//   RAMP_SHIFT  1    ramp level = (horizontal_num >> RAMP_SHIFT)[7:0]
// PORTS
//   clk_25          in   1   pixel clock
//   reset           in   1   synchronous, active-high reset
//   horizontal_num  in   10  current pixel column
//   vertical_num    in   10  current pixel line
//   video_on        in   1   high while (h,v) is inside the active area
//   frame_start     in   1   1-cycle pulse, once per frame, during blanking
//   mode_sel        in   2   requested mode: 0 bars, 1 scroll, 2 checker, 3 ramp
//   pause           in   1   high = freeze scroll offset
//   red/green/blue  out  8   pixel colour, registered
//   active_mode     out  2   mode currently being displayed
//   frame_cnt       out  8   frames since reset, wraps 255->0
// BEHAVIOUR
//   Reset (clk_25 edge with reset=1): red=green=blue=0, active_mode=0,
//     frame_cnt=0, scroll_off=0. Reset has priority over every other input,
//     including in mid-line and mid-frame; the first pixel after reset uses
//     mode 0 with offset 0.
//   Latency: exactly 1 clk_25 cycle from (h, v, video_on) to the colour outputs.
//   Blanking: registered video_on=0 -> R/G/B=0, whatever the mode.
//   Frame update, only on a cycle with frame_start=1:
//     active_mode <= mode_sel; frame_cnt <= frame_cnt+1 (wraps mod 256).
//     scroll_off: if the new mode is not 1 -> 0.
//       Else if pause=1 -> held.
//       Else off+SCROLL_STEP, minus HVID if the result is >= HVID.
//     Outside frame_start, mode_sel and pause are ignored.
//   eff_x = horizontal_num + scroll_off, minus HVID if the result is >= HVID.
//     Use 11-bit intermediate, no overflow.
//   Bar index b = eff_x / BAR_W, in range 0..N_BARS-1. Build it from a compare
//     chain against k*BAR_W; no divider.
//   Palette index b (R,G,B):
//     0 FF,00,00   1 00,FF,00   2 00,00,FF   3 FF,FF,FF
//     4 FF,FF,00   5 00,FF,FF   6 FF,00,FF   7 00,00,00
//   Mode 0: palette[b] with scroll_off = 0.
//   Mode 1: palette[b] with the current scroll_off.
//   Mode 2: hv[CHK_LOG2] ^ vertical_num[CHK_LOG2] = 1 -> FF,FF,FF, else 00,00,00.
//   Mode 3: R = G = B = (horizontal_num >> RAMP_SHIFT)[7:0]; wraps, no saturation.
//   h >= HVID or v >= VVID while video_on=1 is out of contract. The output
//     is then forced to 0 and there is no other side effect.
//   frame_start at the same time as reset: reset wins, frame_cnt stays 0.
// TESTING
//   1 Reset, no frame_start, video_on=1. h=0/159/160/479/480/639 ->
//     next cycle RGB = FF0000/FF0000/00FF00/0000FF/FFFFFF/FFFFFF.
//   2 N_BARS=8: h=80k for k=0..7 -> palette[k]. h=79 -> FF0000.
//   3 mode_sel=1, 160 frame_start pulses -> scroll_off=0 (640 wrap).
//     After 1 pulse, h=156 -> 00FF00. After 40 pulses (off=160), h=0 -> 00FF00.
//   4 Scroll mode with pause=1 across 3 pulses -> offset unchanged, frame_cnt+3.
//     mode_sel change with no pulse -> active_mode unchanged.
//   5 Mode 2: (h,v)=(0,0)->000000, (32,0)->FFFFFF, (32,32)->000000.
//     Mode 3: h=2->010101, h=511->FFFFFF, h=512->000000.
//   6 Assert reset mid-line in mode 1 with off=200 -> next cycle RGB=0,
//     active_mode=0, frame_cnt=0. After release, h=0 -> FF0000.
//     Also: video_on=0 gives RGB=0 in every mode.

Source files
------------

// File: rtl/test_pattern_gen_if.sv
// Pixel bus between the sync/timing generator and the test-pattern source.
// The timing side drives coordinates and frame control; the pattern side returns colour.
interface test_pattern_gen_if;
    logic [9:0] horizontal_num;
    logic [9:0] vertical_num;
    logic       video_on;
    logic       frame_start;
    logic [1:0] mode_sel;
    logic       pause;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [1:0] active_mode;
    logic [7:0] frame_cnt;

    modport master (
        output horizontal_num, vertical_num, video_on,
        output frame_start, mode_sel, pause,
        input  red, green, blue, active_mode, frame_cnt
    );

    modport slave (
        input  horizontal_num, vertical_num, video_on,
        input  frame_start, mode_sel, pause,
        output red, green, blue, active_mode, frame_cnt
    );
endinterface

// File: rtl/test_pattern_gen.sv
// Registered VGA test-pattern source: bars, scrolling bars, checker, ramp.
// Mode and scroll offset only change on frame_start so frames never tear.
module test_pattern_gen #(
    parameter int HVID        = 640,
    parameter int VVID        = 480,
    parameter int N_BARS      = 4,
    parameter int SCROLL_STEP = 4,
    parameter int CHK_LOG2    = 5,
    parameter int RAMP_SHIFT  = 1
) (
    input logic               clk_25,
    input logic               reset,
    test_pattern_gen_if.slave pix
);
    localparam int          BAR_W  = HVID / N_BARS;
    localparam logic [10:0] HVID_W = 11'(HVID);
    localparam logic [10:0] VVID_W = 11'(VVID);
    localparam logic [10:0] STEP_W = 11'(SCROLL_STEP);

    logic [1:0]  mode_q;
    logic [7:0]  frame_q;
    logic [9:0]  scroll_off;
    logic [10:0] off_sum;
    logic [10:0] off_next;
    logic [10:0] x_sum;
    logic [10:0] eff_x;
    logic [2:0]  bar;
    logic [23:0] bar_rgb;
    logic [23:0] pix_rgb;
    logic [23:0] rgb_q;
    logic [7:0]  ramp;
    logic        in_area;
    logic        chk;

    // Next scroll offset, wrapped back into 0..HVID-1.
    always_comb begin
        off_sum  = {1'b0, scroll_off} + STEP_W;
        off_next = (off_sum >= HVID_W) ? off_sum - HVID_W : off_sum;
    end

    // Frame-boundary state: displayed mode, frame counter, scroll offset.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            mode_q     <= 2'd0;
            frame_q    <= 8'd0;
            scroll_off <= 10'd0;
        end else if (pix.frame_start) begin
            mode_q  <= pix.mode_sel;
            frame_q <= frame_q + 8'd1;
            if (pix.mode_sel != 2'd1)
                scroll_off <= 10'd0;
            else if (!pix.pause)
                scroll_off <= off_next[9:0];
        end
    end

    // Scrolled column and bar index via a compare chain (no divider).
    always_comb begin
        x_sum = {1'b0, pix.horizontal_num};
        if (mode_q == 2'd1)
            x_sum = x_sum + {1'b0, scroll_off};
        eff_x = (x_sum >= HVID_W) ? x_sum - HVID_W : x_sum;
        bar   = 3'd0;
        for (int k = 1; k < N_BARS; k++) begin
            if (eff_x >= 11'(k * BAR_W))
                bar = 3'(k);
        end
    end

    // Bar palette lookup.
    always_comb begin
        bar_rgb = 24'h000000;
        unique case (bar)
            3'd0: bar_rgb = 24'hFF0000;
            3'd1: bar_rgb = 24'h00FF00;
            3'd2: bar_rgb = 24'h0000FF;
            3'd3: bar_rgb = 24'hFFFFFF;
            3'd4: bar_rgb = 24'hFFFF00;
            3'd5: bar_rgb = 24'h00FFFF;
            3'd6: bar_rgb = 24'hFF00FF;
            3'd7: bar_rgb = 24'h000000;
        endcase
    end

    // Per-mode colour, blanked outside the active area.
    always_comb begin
        in_area = pix.video_on
               && ({1'b0, pix.horizontal_num} < HVID_W)
               && ({1'b0, pix.vertical_num} < VVID_W);
        chk  = pix.horizontal_num[CHK_LOG2] ^ pix.vertical_num[CHK_LOG2];
        ramp = 8'(pix.horizontal_num >> RAMP_SHIFT);
        pix_rgb = 24'h000000;
        unique case (mode_q)
            2'd0, 2'd1: pix_rgb = bar_rgb;
            2'd2:       pix_rgb = chk ? 24'hFFFFFF : 24'h000000;
            2'd3:       pix_rgb = {ramp, ramp, ramp};
        endcase
        if (!in_area)
            pix_rgb = 24'h000000;
    end

    // One-cycle colour register.
    always_ff @(posedge clk_25) begin
        if (reset)
            rgb_q <= 24'h000000;
        else
            rgb_q <= pix_rgb;
    end

    assign pix.red         = rgb_q[23:16];
    assign pix.green       = rgb_q[15:8];
    assign pix.blue        = rgb_q[7:0];
    assign pix.active_mode = mode_q;
    assign pix.frame_cnt   = frame_q;
endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: 4-bar instance plus an 8-bar instance
// sharing the same stimulus.
module tb_test_pattern_gen;
    logic       clk_25 = 1'b0;
    logic       reset;
    logic [9:0] h;
    logic [9:0] v;
    logic       vid;
    logic       fs;
    logic [1:0] msel;
    logic       pause;
    int         n_cmp = 0;
    int         n_err = 0;

    test_pattern_gen_if ia ();
    test_pattern_gen_if ib ();

    assign ia.horizontal_num = h;
    assign ia.vertical_num   = v;
    assign ia.video_on       = vid;
    assign ia.frame_start    = fs;
    assign ia.mode_sel       = msel;
    assign ia.pause          = pause;
    assign ib.horizontal_num = h;
    assign ib.vertical_num   = v;
    assign ib.video_on       = vid;
    assign ib.frame_start    = fs;
    assign ib.mode_sel       = msel;
    assign ib.pause          = pause;

    test_pattern_gen dut_a (
        .clk_25 (clk_25),
        .reset  (reset),
        .pix    (ia)
    );

    test_pattern_gen #(.N_BARS(8)) dut_b (
        .clk_25 (clk_25),
        .reset  (reset),
        .pix    (ib)
    );

    always #20 clk_25 = ~clk_25;

    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
    assign rgb_a = {ia.red, ia.green, ia.blue};
    assign rgb_b = {ib.red, ib.green, ib.blue};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic px(input logic [9:0] hh, input logic [9:0] vv,
                      input logic von);
        h   = hh;
        v   = vv;
        vid = von;
        tick();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            fs = 1'b1;
            tick();
            fs = 1'b0;
        end
    endtask

    logic [9:0]  h4 [6]  = '{10'd0, 10'd159, 10'd160, 10'd479, 10'd480, 10'd639};
    logic [23:0] e4 [6]  = '{24'hFF0000, 24'hFF0000, 24'h00FF00,
                             24'h0000FF, 24'hFFFFFF, 24'hFFFFFF};
    logic [23:0] pal [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                             24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000};

    initial begin
        reset = 1'b1;
        h     = 10'd0;
        v     = 10'd0;
        vid   = 1'b1;
        fs    = 1'b1;
        msel  = 2'd1;
        pause = 1'b0;
        tick();
        check("rst_rgb", 32'(rgb_a), 32'h0);
        check("rst_mode", 32'(ia.active_mode), 32'd0);
        check("rst_fcnt", 32'(ia.frame_cnt), 32'd0);
        fs    = 1'b0;
        msel  = 2'd0;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            px(h4[i], 10'd0, 1'b1);
            check($sformatf("bars4_h%0d", h4[i]), 32'(rgb_a), 32'(e4[i]));
        end

        for (int k = 0; k < 8; k++) begin
            px(10'(80 * k), 10'd5, 1'b1);
            check($sformatf("bars8_k%0d", k), 32'(rgb_b), 32'(pal[k]));
        end
        px(10'd79, 10'd5, 1'b1);
        check("bars8_h79", 32'(rgb_b), 32'hFF0000);

        msel = 2'd1;
        pulses(1);
        check("scr_mode", 32'(ia.active_mode), 32'd1);
        px(10'd156, 10'd0, 1'b1);
        check("scr1_h156", 32'(rgb_a), 32'h00FF00);
        px(10'd155, 10'd0, 1'b1);
        check("scr1_h155", 32'(rgb_a), 32'hFF0000);
        pulses(39);
        px(10'd0, 10'd0, 1'b1);
        check("scr40_h0", 32'(rgb_a), 32'h00FF00);
        px(10'd480, 10'd0, 1'b1);
        check("scr40_h480", 32'(rgb_a), 32'hFF0000);
        pulses(120);
        px(10'd0, 10'd0, 1'b1);
        check("scr160_h0", 32'(rgb_a), 32'hFF0000);
        px(10'd160, 10'd0, 1'b1);
        check("scr160_h160", 32'(rgb_a), 32'h00FF00);
        check("scr160_fcnt", 32'(ia.frame_cnt), 32'd160);

        pulses(50);
        pause = 1'b1;
        pulses(3);
        pause = 1'b0;
        check("pause_fcnt", 32'(ia.frame_cnt), 32'd213);
        px(10'd0, 10'd0, 1'b1);
        check("pause_h0", 32'(rgb_a), 32'h00FF00);
        px(10'd439, 10'd0, 1'b1);
        check("pause_h439", 32'(rgb_a), 32'hFFFFFF);
        px(10'd440, 10'd0, 1'b1);
        check("pause_h440", 32'(rgb_a), 32'hFF0000);
        msel = 2'd2;
        px(10'd0, 10'd0, 1'b1);
        px(10'd0, 10'd0, 1'b1);
        check("nopulse_mode", 32'(ia.active_mode), 32'd1);

        h     = 10'd300;
        vid   = 1'b1;
        reset = 1'b1;
        fs    = 1'b1;
        tick();
        check("midrst_rgb", 32'(rgb_a), 32'h0);
        check("midrst_mode", 32'(ia.active_mode), 32'd0);
        check("midrst_fcnt", 32'(ia.frame_cnt), 32'd0);
        reset = 1'b0;
        fs    = 1'b0;
        px(10'd0, 10'd0, 1'b1);
        check("postrst_h0", 32'(rgb_a), 32'hFF0000);
        px(10'd440, 10'd0, 1'b1);
        check("postrst_h440", 32'(rgb_a), 32'h0000FF);
        msel  = 2'd1;
        pause = 1'b1;
        pulses(1);
        pause = 1'b0;
        px(10'd159, 10'd0, 1'b1);
        check("rst_off_h159", 32'(rgb_a), 32'hFF0000);

        msel = 2'd2;
        pulses(1);
        px(10'd0, 10'd0, 1'b1);
        check("chk_0_0", 32'(rgb_a), 32'h000000);
        px(10'd32, 10'd0, 1'b1);
        check("chk_32_0", 32'(rgb_a), 32'hFFFFFF);
        px(10'd32, 10'd32, 1'b1);
        check("chk_32_32", 32'(rgb_a), 32'h000000);
        px(10'd0, 10'd32, 1'b1);
        check("chk_0_32", 32'(rgb_a), 32'hFFFFFF);

        msel = 2'd3;
        pulses(1);
        px(10'd2, 10'd0, 1'b1);
        check("ramp_h2", 32'(rgb_a), 32'h010101);
        px(10'd511, 10'd0, 1'b1);
        check("ramp_h511", 32'(rgb_a), 32'hFFFFFF);
        px(10'd512, 10'd0, 1'b1);
        check("ramp_h512", 32'(rgb_a), 32'h000000);
        px(10'd639, 10'd0, 1'b1);
        check("ramp_h639", 32'(rgb_a), 32'h3F3F3F);
        check("fcnt_3", 32'(ia.frame_cnt), 32'd3);

        for (int m = 0; m < 4; m++) begin
            msel = 2'(m);
            pulses(1);
            px(10'd511, 10'd32, 1'b0);
            check($sformatf("blank_m%0d", m), 32'(rgb_a), 32'h0);
        end
        px(10'd640, 10'd0, 1'b1);
        check("oob_h640", 32'(rgb_a), 32'h0);
        px(10'd0, 10'd480, 1'b1);
        check("oob_v480", 32'(rgb_a), 32'h0);
        px(10'd600, 10'd0, 1'b1);
        check("ramp_after_oob", 32'(rgb_a), 32'h2C2C2C);

        pulses(248);
        check("fcnt_255", 32'(ia.frame_cnt), 32'd255);
        pulses(1);
        check("fcnt_wrap", 32'(ia.frame_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
